// File: rtl/temp_alarm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// temp_alarm_ctrl_pkg
// Shared definitions for the temperature alarm controller: tenths-of-a-degree
// width and limits, alarm FSM state encoding, and the reading-to-tenths
// conversion helper.
// ---------------------------------------------------------------------------
package temp_alarm_ctrl_pkg;

   localparam int unsigned TENTHS_W   = 11;
   localparam int unsigned TENTHS_MAX = 1279;  // 127.9 degC, largest legal reading
   localparam int unsigned TENTHS_SAT = 2047;  // all-ones of TENTHS_W
   localparam int unsigned CNT_W      = 4;     // confirmation counter, CONFIRM <= 15

   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_NORMAL   = 3'd1,
      ST_HI_PEND  = 3'd2,
      ST_HI_ALARM = 3'd3,
      ST_LO_PEND  = 3'd4,
      ST_LO_ALARM = 3'd5
   } alarm_state_e;

   // Integer degrees plus tenths digit to tenths; digit clamped to 9 and the
   // result clamped to the legal reading range.
   function automatic logic [TENTHS_W-1:0] to_tenths(input logic [7:0] t_int,
                                                      input logic [7:0] t_deci);
      logic [3:0]  deci;
      logic [11:0] full;
      deci = (t_deci > 8'd9) ? 4'd9 : t_deci[3:0];
      full = 12'(t_int) * 12'd10 + 12'(deci);
      return (full > 12'(TENTHS_MAX)) ? TENTHS_W'(TENTHS_MAX) : full[TENTHS_W-1:0];
   endfunction

endpackage

// File: rtl/temp_alarm_ctrl_if.sv
// ---------------------------------------------------------------------------
// temp_alarm_ctrl_if
// Reading bus from the DS18B20 driver.
//   temp_int  [7:0] : integer degC
//   temp_deci [7:0] : tenths digit
//   temp_done       : reading-valid level, several sys_clk wide, driver clock
// master = sensor driver, slave = alarm controller.
// ---------------------------------------------------------------------------
interface temp_alarm_ctrl_if;

   logic [7:0] temp_int;
   logic [7:0] temp_deci;
   logic       temp_done;

   modport master (output temp_int, output temp_deci, output temp_done);
   modport slave  (input  temp_int, input  temp_deci, input  temp_done);

endinterface

// File: rtl/temp_alarm_ctrl_avg_filter.sv
// ---------------------------------------------------------------------------
// temp_alarm_ctrl_avg_filter
// Power-of-two moving average over the last 2^AVG_LOG2 samples.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   sample, sample_vld : new sample in tenths and its one-cycle strobe
//   prime              : fill whole window with this sample (no history)
//   avg, avg_vld       : registered average and its one-cycle strobe
// Latency: sum updates one cycle after sample_vld, avg one cycle later.
// ---------------------------------------------------------------------------
module temp_alarm_ctrl_avg_filter
   import temp_alarm_ctrl_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [TENTHS_W-1:0] sample,
   input  logic                sample_vld,
   input  logic                prime,
   output logic [TENTHS_W-1:0] avg,
   output logic                avg_vld
);

   localparam int unsigned DEPTH = 1 << AVG_LOG2;
   localparam int unsigned PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam int unsigned SUM_W = TENTHS_W + AVG_LOG2;

   logic [TENTHS_W-1:0] hist_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [SUM_W-1:0]    sum_q;
   logic                sum_vld_q;

   // Window history and running sum; wr_ptr always points at the oldest entry.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin : window_sum
      if (!sys_rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= '0;
         wr_ptr_q  <= '0;
         sum_q     <= '0;
         sum_vld_q <= 1'b0;
      end else begin
         sum_vld_q <= sample_vld;
         if (sample_vld) begin
            if (prime) begin
               for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= sample;
               sum_q <= SUM_W'(sample) << AVG_LOG2;
            end else begin
               hist_q[wr_ptr_q] <= sample;
               sum_q            <= sum_q - SUM_W'(hist_q[wr_ptr_q]) + SUM_W'(sample);
               if (wr_ptr_q == PTR_W'(DEPTH - 1)) wr_ptr_q <= '0;
               else                               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
         end
      end
   end

   // Truncating divide by the window size.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin : avg_out
      if (!sys_rst_n) begin
         avg     <= '0;
         avg_vld <= 1'b0;
      end else begin
         avg_vld <= sum_vld_q;
         if (sum_vld_q) avg <= TENTHS_W'(sum_q >> AVG_LOG2);
      end
   end

endmodule

// File: rtl/temp_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// temp_alarm_ctrl
// Turns DS18B20 readings into a filtered temperature, high/low alarms with
// confirmation and hysteresis, and a sensor-fault flag on missing readings.
// Ports:
//   sys_clk, sys_rst_n     : 50 MHz clock, async active-low reset
//   sensor (slave)         : temp_int / temp_deci / temp_done reading bus
//   th_high, th_low  [10:0]: alarm thresholds in tenths
//   minmax_clr             : clear min/max tracking
//   avg_tenths [10:0]      : filtered temperature, avg_valid one-cycle strobe
//   alarm_high, alarm_low  : alarm levels
//   sensor_fault           : no reading within TIMEOUT_CYC cycles
//   t_min, t_max   [10:0]  : min/max average since reset or clear
// Optional: define TEMP_MINMAX_EN to enable min/max tracking; otherwise
// t_min/t_max are tied to 0 and minmax_clr is ignored.
// Pipeline: rise -> sample (+1) -> sum (+2) -> avg (+3) -> alarm FSM (+4).
// ---------------------------------------------------------------------------
module temp_alarm_ctrl
   import temp_alarm_ctrl_pkg::*;
#(
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned CONFIRM     = 3,
   parameter int unsigned HYST        = 10,
   parameter int unsigned TIMEOUT_CYC = 150_000_000
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   temp_alarm_ctrl_if.slave    sensor,
   input  logic [TENTHS_W-1:0] th_high,
   input  logic [TENTHS_W-1:0] th_low,
   input  logic                minmax_clr,
   output logic [TENTHS_W-1:0] avg_tenths,
   output logic                avg_valid,
   output logic                alarm_high,
   output logic                alarm_low,
   output logic                sensor_fault,
   output logic [TENTHS_W-1:0] t_min,
   output logic [TENTHS_W-1:0] t_max
);

   localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic                done_s1, done_s2, done_s3;
   logic                rise_c;
   logic [TENTHS_W-1:0] sample_q;
   logic                sample_vld_q;
   logic [TO_W-1:0]     to_cnt_q;
   logic                to_max_c;
   logic                timeout_hit_c;
   alarm_state_e        state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                above_c, below_c;
   logic [TENTHS_W-1:0] hi_exit_c, lo_exit_c;
   logic [TENTHS_W:0]   lo_sum_c;

   // temp_done comes from the driver clock domain.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin : done_sync
      if (!sys_rst_n) begin
         done_s1 <= 1'b0;
         done_s2 <= 1'b0;
         done_s3 <= 1'b0;
      end else begin
         done_s1 <= sensor.temp_done;
         done_s2 <= done_s1;
         done_s3 <= done_s2;
      end
   end

   assign rise_c = done_s2 & ~done_s3;

   // Data is stable while temp_done is high, so it is safe to sample on rise.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin : convert
      if (!sys_rst_n) begin
         sample_q     <= '0;
         sample_vld_q <= 1'b0;
      end else begin
         sample_vld_q <= rise_c;
         if (rise_c) sample_q <= to_tenths(sensor.temp_int, sensor.temp_deci);
      end
   end

   // Window is re-primed whenever the FSM has no valid history.
   temp_alarm_ctrl_avg_filter #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg_filter (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .sample     (sample_q),
      .sample_vld (sample_vld_q),
      .prime      (state_q == ST_INIT),
      .avg        (avg_tenths),
      .avg_vld    (avg_valid)
   );

   // Missing-reading watchdog; a rise in the expiry cycle takes precedence.
   assign to_max_c      = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
   assign timeout_hit_c = to_max_c & ~rise_c;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin : watchdog
      if (!sys_rst_n) begin
         to_cnt_q     <= '0;
         sensor_fault <= 1'b0;
      end else if (rise_c) begin
         to_cnt_q     <= '0;
         sensor_fault <= 1'b0;
      end else if (to_max_c) begin
         sensor_fault <= 1'b1;
      end else begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end

   // Threshold compares and saturating hysteresis exit points.
   assign above_c   = (avg_tenths > th_high);
   assign below_c   = (avg_tenths < th_low);
   assign hi_exit_c = (th_high >= TENTHS_W'(HYST)) ? (th_high - TENTHS_W'(HYST)) : '0;
   assign lo_sum_c  = (TENTHS_W + 1)'(th_low) + (TENTHS_W + 1)'(HYST);
   assign lo_exit_c = (lo_sum_c > (TENTHS_W + 1)'(TENTHS_SAT)) ? TENTHS_W'(TENTHS_SAT)
                                                             : lo_sum_c[TENTHS_W-1:0];

   // Alarm FSM; alarm levels are registered alongside each state change.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin : alarm_fsm
      if (!sys_rst_n) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         alarm_high <= 1'b0;
         alarm_low  <= 1'b0;
      end else if (timeout_hit_c) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         alarm_high <= 1'b0;
         alarm_low  <= 1'b0;
      end else if (avg_valid) begin
         case (state_q)
            ST_INIT, ST_NORMAL: begin
               // High wins when the thresholds overlap.
               if (above_c) begin
                  if (CONFIRM <= 1) begin
                     state_q    <= ST_HI_ALARM;
                     alarm_high <= 1'b1;
                  end else begin
                     state_q <= ST_HI_PEND;
                     cnt_q   <= CNT_W'(1);
                  end
               end else if (below_c) begin
                  if (CONFIRM <= 1) begin
                     state_q   <= ST_LO_ALARM;
                     alarm_low <= 1'b1;
                  end else begin
                     state_q <= ST_LO_PEND;
                     cnt_q   <= CNT_W'(1);
                  end
               end else begin
                  state_q <= ST_NORMAL;
               end
            end
            ST_HI_PEND: begin
               if (!above_c) begin
                  state_q <= ST_NORMAL;
                  cnt_q   <= '0;
               end else if (cnt_q + CNT_W'(1) >= CNT_W'(CONFIRM)) begin
                  state_q    <= ST_HI_ALARM;
                  cnt_q      <= '0;
                  alarm_high <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HI_ALARM: begin
               if (avg_tenths <= hi_exit_c) begin
                  state_q    <= ST_NORMAL;
                  alarm_high <= 1'b0;
               end
            end
            ST_LO_PEND: begin
               if (!below_c) begin
                  state_q <= ST_NORMAL;
                  cnt_q   <= '0;
               end else if (cnt_q + CNT_W'(1) >= CNT_W'(CONFIRM)) begin
                  state_q   <= ST_LO_ALARM;
                  cnt_q     <= '0;
                  alarm_low <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_LO_ALARM: begin
               if (avg_tenths >= lo_exit_c) begin
                  state_q   <= ST_NORMAL;
                  alarm_low <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_INIT;
               cnt_q      <= '0;
               alarm_high <= 1'b0;
               alarm_low  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TEMP_MINMAX_EN
   logic first_q;

   // Min/max of the filtered value; first_q makes the next average load both.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin : minmax_track
      if (!sys_rst_n) begin
         t_min   <= '0;
         t_max   <= '0;
         first_q <= 1'b1;
      end else if (minmax_clr) begin
         if (avg_valid) begin
            t_min   <= avg_tenths;
            t_max   <= avg_tenths;
            first_q <= 1'b0;
         end else begin
            t_min   <= '0;
            t_max   <= '0;
            first_q <= 1'b1;
         end
      end else if (avg_valid) begin
         if (first_q) begin
            t_min   <= avg_tenths;
            t_max   <= avg_tenths;
            first_q <= 1'b0;
         end else begin
            if (avg_tenths < t_min) t_min <= avg_tenths;
            if (avg_tenths > t_max) t_max <= avg_tenths;
         end
      end
   end
`else
   logic unused_minmax_clr;
   assign unused_minmax_clr = minmax_clr;
   assign t_min             = '0;
   assign t_max             = '0;
`endif

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_temp_alarm_ctrl
// Directed bench for temp_alarm_ctrl with AVG_LOG2=2, CONFIRM=3, HYST=10,
// TIMEOUT_CYC=1000. Expected averages are hand-computed from a 4-deep window.
// ---------------------------------------------------------------------------
module tb_temp_alarm_ctrl;

   localparam int unsigned TIMEOUT_CYC = 1000;
   // rise lands 3 edges after temp_done is driven; do_reading returns 60
   // edges after driving, so the fault follows this many edges later.
   localparam int RISE_EDGE  = 3;
   localparam int TASK_EDGES = 60;
   localparam int FAULT_WAIT = int'(TIMEOUT_CYC) + RISE_EDGE - TASK_EDGES;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [10:0] th_high, th_low;
   logic        minmax_clr;
   logic [10:0] avg_tenths;
   logic        avg_valid;
   logic        alarm_high, alarm_low, sensor_fault;
   logic [10:0] t_min, t_max;

   int n_checks = 0;
   int n_pass   = 0;

   temp_alarm_ctrl_if sensor_if ();

   temp_alarm_ctrl #(
      .AVG_LOG2    (2),
      .CONFIRM     (3),
      .HYST        (10),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .sensor       (sensor_if),
      .th_high      (th_high),
      .th_low       (th_low),
      .minmax_clr   (minmax_clr),
      .avg_tenths   (avg_tenths),
      .avg_valid    (avg_valid),
      .alarm_high   (alarm_high),
      .alarm_low    (alarm_low),
      .sensor_fault (sensor_fault),
      .t_min        (t_min),
      .t_max        (t_max)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic apply_reset();
      @(posedge sys_clk); #1;
      sys_rst_n               = 1'b0;
      sensor_if.temp_done     = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
   endtask

   // One reading: temp_done held 50 cycles, then 10 idle cycles.
   task automatic do_reading(input int ti, input int td, input int exp_avg,
                             input string tag, output int lat);
      int got_avg;
      int pulses;
      got_avg = -1;
      pulses  = 0;
      lat     = -1;
      @(posedge sys_clk); #1;
      sensor_if.temp_int  = 8'(ti);
      sensor_if.temp_deci = 8'(td);
      sensor_if.temp_done = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         @(posedge sys_clk); #1;
         if (avg_valid) begin
            pulses++;
            if (lat < 0) begin
               lat     = i;
               got_avg = int'(avg_tenths);
            end
         end
      end
      sensor_if.temp_done = 1'b0;
      repeat (10) @(posedge sys_clk);
      #1;
      check_eq({tag, "_avg"}, got_avg, exp_avg);
      check_eq({tag, "_pulses"}, pulses, 1);
   endtask

   task automatic wait_fault(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 1200; i++) begin
         @(posedge sys_clk); #1;
         if (sensor_fault) begin
            seen = 1;
            break;
         end
      end
      check_eq(tag, seen, 1);
   endtask

   initial begin
      int lat;
      int vld_seen;
      int n_fault;
      int ah_before;
      int exp_min, exp_max;

      sys_rst_n           = 1'b0;
      sensor_if.temp_int  = '0;
      sensor_if.temp_deci = '0;
      sensor_if.temp_done = 1'b0;
      th_high             = 11'd300;
      th_low              = 11'd100;
      minmax_clr          = 1'b0;

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      check_eq("rst_avg", int'(avg_tenths), 0);
      check_eq("rst_valid", int'(avg_valid), 0);
      check_eq("rst_alarm_high", int'(alarm_high), 0);
      check_eq("rst_alarm_low", int'(alarm_low), 0);
      check_eq("rst_fault", int'(sensor_fault), 0);
      check_eq("rst_tmin", int'(t_min), 0);
      check_eq("rst_tmax", int'(t_max), 0);
      sys_rst_n = 1'b1;

      // Priming: 25.3 fills the window, avg_valid 5 cycles after the edge
      do_reading(25, 3, 253, "prime", lat);
      check_eq("prime_latency", lat, 5);
      check_eq("prime_alarm_high", int'(alarm_high), 0);
      check_eq("prime_alarm_low", int'(alarm_low), 0);

      // Reset while a sample is in the pipeline: no pulse may emerge
      @(posedge sys_clk); #1;
      sensor_if.temp_int  = 8'd60;
      sensor_if.temp_deci = 8'd0;
      sensor_if.temp_done = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst_n           = 1'b0;
      sensor_if.temp_done = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      vld_seen  = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge sys_clk); #1;
         if (avg_valid) vld_seen++;
      end
      check_eq("midrst_pulses", vld_seen, 0);
      check_eq("midrst_avg", int'(avg_tenths), 0);

      // Averaging: 250 primes, then 290s step the average by 10
      do_reading(25, 0, 250, "avg0", lat);
      do_reading(29, 0, 260, "avg1", lat);
      do_reading(29, 0, 270, "avg2", lat);
      do_reading(29, 0, 280, "avg3", lat);
      do_reading(29, 0, 290, "avg4", lat);
      check_eq("avg4_alarm_high", int'(alarm_high), 0);

      // High alarm: window [290x4]; 350,310,270 give 305,310,305
      do_reading(35, 0, 305, "hi1", lat);
      check_eq("hi1_alarm", int'(alarm_high), 0);
      do_reading(31, 0, 310, "hi2", lat);
      check_eq("hi2_alarm", int'(alarm_high), 0);
      do_reading(27, 0, 305, "hi3", lat);
      check_eq("hi3_alarm", int'(alarm_high), 1);
      // 250 -> 295, above exit point 290: stays set
      do_reading(25, 0, 295, "hi4", lat);
      check_eq("hi4_alarm", int'(alarm_high), 1);
      // 330 replaces 350 -> 290: clears
      do_reading(33, 0, 290, "hi5", lat);
      check_eq("hi5_alarm", int'(alarm_high), 0);

      // Low pending abort: 95, 95, then 195 -> avg 120
      apply_reset();
      do_reading(9, 5, 95, "lo1", lat);
      check_eq("lo1_alarm", int'(alarm_low), 0);
      do_reading(9, 5, 95, "lo2", lat);
      check_eq("lo2_alarm", int'(alarm_low), 0);
      do_reading(19, 5, 120, "lo3", lat);
      check_eq("lo3_alarm", int'(alarm_low), 0);
      // A 4th low average would alarm only if pending had not been aborted
      // (window [95,95,195,50] -> 435/4 = 108, not below 100)
      do_reading(5, 0, 108, "lo4", lat);
      check_eq("lo4_alarm", int'(alarm_low), 0);

      // Timeout while alarm_high is set
      apply_reset();
      do_reading(40, 0, 400, "to1", lat);
      do_reading(40, 0, 400, "to2", lat);
      check_eq("to2_alarm", int'(alarm_high), 0);
      do_reading(40, 0, 400, "to3", lat);
      check_eq("to3_alarm", int'(alarm_high), 1);
      n_fault   = -1;
      ah_before = -1;
      for (int i = 1; i <= 1200; i++) begin
         @(posedge sys_clk); #1;
         if (sensor_fault) begin
            n_fault = i;
            break;
         end
         ah_before = int'(alarm_high);
      end
      check_eq("timeout_cycles", n_fault, FAULT_WAIT);
      check_eq("alarm_before_fault", ah_before, 1);
      check_eq("alarm_at_fault", int'(alarm_high), 0);
      repeat (20) @(posedge sys_clk);
      #1;
      check_eq("fault_holds", int'(sensor_fault), 1);
      // Recovery reading re-primes: 200, not a blend with the old 400s
      do_reading(20, 0, 200, "recover", lat);
      check_eq("recover_fault", int'(sensor_fault), 0);
      check_eq("recover_alarm_high", int'(alarm_high), 0);

      // Min/max: fault between readings so each one primes the window
`ifdef TEMP_MINMAX_EN
      exp_min = 180;
      exp_max = 310;
`else
      exp_min = 0;
      exp_max = 0;
`endif
      apply_reset();
      do_reading(25, 0, 250, "mm1", lat);
      wait_fault("mm1_fault");
      do_reading(31, 0, 310, "mm2", lat);
      wait_fault("mm2_fault");
      do_reading(18, 0, 180, "mm3", lat);
      check_eq("mm_tmin", int'(t_min), exp_min);
      check_eq("mm_tmax", int'(t_max), exp_max);
      @(posedge sys_clk); #1;
      minmax_clr = 1'b1;
      @(posedge sys_clk); #1;
      minmax_clr = 1'b0;
      check_eq("mm_clr_tmin", int'(t_min), 0);
      check_eq("mm_clr_tmax", int'(t_max), 0);
      // window [180x4]; 340 -> 880/4 = 220
`ifdef TEMP_MINMAX_EN
      exp_min = 220;
      exp_max = 220;
`endif
      do_reading(34, 0, 220, "mm4", lat);
      check_eq("mm4_tmin", int'(t_min), exp_min);
      check_eq("mm4_tmax", int'(t_max), exp_max);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
